// File: rtl/regfile_arbiter_pkg.sv
// Shared definitions for the register-file command-port arbiter:
// default widths, requester IDs and the lock FSM state encoding.
package regfile_arbiter_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_MAX_LOCK = 4;

    // Wide enough for any MAX_LOCK in 1..15.
    localparam int CNT_W = 4;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_arbiter_rr_grant2.sv
// Two-input round-robin picker: grants the lone valid requester, or the one
// named by ptr when both are valid; ptr_next points at the loser.
module regfile_arbiter_rr_grant2
    import regfile_arbiter_pkg::*;
(
    input  logic v0,
    input  logic v1,
    input  logic ptr,
    output logic gnt_any,
    output logic gnt_id,
    output logic ptr_next
);

    always_comb begin
        gnt_any = v0 | v1;
        if (v0 && v1) begin
            gnt_id = ptr;
        end else if (v1) begin
            gnt_id = REQ1;
        end else begin
            gnt_id = REQ0;
        end
        ptr_next = ~gnt_id;
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the register file's single command port between two requesters with
// round-robin fairness, bounded lock ownership and a one-cycle response stage.
module regfile_arbiter
    import regfile_arbiter_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic              req0_lock,
    input  logic [ADDR_W-1:0] req0_aa,
    input  logic [ADDR_W-1:0] req0_ba,
    input  logic [ADDR_W-1:0] req0_da,
    input  logic [DATA_W-1:0] req0_wd,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_a,
    output logic [DATA_W-1:0] rsp0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic              req1_lock,
    input  logic [ADDR_W-1:0] req1_aa,
    input  logic [ADDR_W-1:0] req1_ba,
    input  logic [ADDR_W-1:0] req1_da,
    input  logic [DATA_W-1:0] req1_wd,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_a,
    output logic [DATA_W-1:0] rsp1_b,

    output logic              rf_en,
    output logic              rf_rw,
    output logic [ADDR_W-1:0] rf_aa,
    output logic [ADDR_W-1:0] rf_ba,
    output logic [ADDR_W-1:0] rf_da,
    output logic [DATA_W-1:0] rf_d,
    input  logic [DATA_W-1:0] rf_a,
    input  logic [DATA_W-1:0] rf_b
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

    state_t           state;
    logic             ptr;
    logic             owner;
    logic [CNT_W-1:0] lock_cnt;
    logic             rsp_pend;
    logic             rsp_sel;

    logic [1:0] req_valid;
    logic [1:0] pick_valid;
    logic       other;
    logic       force_rel;
    logic       gnt;
    logic       gnt_id;
    logic       gnt_lock;
    logic       ptr_next;

    assign req_valid = {req1_valid, req0_valid};
    assign other     = ~owner;
    assign force_rel = (state == OWNED) && (lock_cnt == MAX_CNT) && req_valid[other];

    // While owned, only one requester is presented to the picker: the owner,
    // or the other side when the owner is absent or being forced out.
    always_comb begin
        pick_valid = req_valid;
        if (state == OWNED) begin
            pick_valid = 2'b00;
            if (req_valid[owner] && !force_rel) begin
                pick_valid[owner] = 1'b1;
            end else begin
                pick_valid[other] = req_valid[other];
            end
        end
        if (rst) begin
            pick_valid = 2'b00;
        end
    end

    regfile_arbiter_rr_grant2 u_rr_grant2 (
        .v0       (pick_valid[0]),
        .v1       (pick_valid[1]),
        .ptr      (ptr),
        .gnt_any  (gnt),
        .gnt_id   (gnt_id),
        .ptr_next (ptr_next)
    );

    assign req0_ready = gnt && (gnt_id == REQ0);
    assign req1_ready = gnt && (gnt_id == REQ1);
    assign gnt_lock   = (gnt_id == REQ1) ? req1_lock : req0_lock;

    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which keeps this block purely combinational (no inferred latches).
    always_comb begin
        rf_en = 1'b0;
        rf_rw = 1'b0;
        rf_aa = '0;
        rf_ba = '0;
        rf_da = '0;
        rf_d  = '0;
        if (gnt) begin
            rf_en = 1'b1;
            if (gnt_id == REQ1) begin
                rf_rw = req1_we;
                rf_aa = req1_aa;
                rf_ba = req1_ba;
                rf_da = req1_da;
                rf_d  = req1_wd;
            end else begin
                rf_rw = req0_we;
                rf_aa = req0_aa;
                rf_ba = req0_ba;
                rf_da = req0_da;
                rf_d  = req0_wd;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= REQ0;
            owner    <= REQ0;
            lock_cnt <= '0;
            rsp_pend <= 1'b0;
            rsp_sel  <= REQ0;
        end else begin
            rsp_pend <= gnt;
            rsp_sel  <= gnt_id;
            if (gnt && gnt_lock) begin
                state <= OWNED;
                owner <= gnt_id;
                if (state == OWNED && owner == gnt_id) begin
                    lock_cnt <= (lock_cnt == MAX_CNT) ? MAX_CNT : lock_cnt + 1'b1;
                end else begin
                    lock_cnt <= CNT_W'(1);
                end
            end else begin
                state    <= IDLE;
                lock_cnt <= '0;
            end
            if (gnt) begin
                ptr <= ptr_next;
            end
        end
    end

    // A response in flight when rst rises is dropped immediately.
    assign rsp0_valid = rsp_pend && !rst && (rsp_sel == REQ0);
    assign rsp1_valid = rsp_pend && !rst && (rsp_sel == REQ1);
    assign rsp0_a     = rsp0_valid ? rf_a : '0;
    assign rsp0_b     = rsp0_valid ? rf_b : '0;
    assign rsp1_a     = rsp1_valid ? rf_a : '0;
    assign rsp1_b     = rsp1_valid ? rf_b : '0;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 16x16 register file.
module tb_regfile_arbiter;
    import regfile_arbiter_pkg::*;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid, req0_ready, req0_we, req0_lock;
    logic [AW-1:0] req0_aa, req0_ba, req0_da;
    logic [DW-1:0] req0_wd;
    logic          rsp0_valid;
    logic [DW-1:0] rsp0_a, rsp0_b;
    logic          req1_valid, req1_ready, req1_we, req1_lock;
    logic [AW-1:0] req1_aa, req1_ba, req1_da;
    logic [DW-1:0] req1_wd;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_a, rsp1_b;
    logic          rf_en, rf_rw;
    logic [AW-1:0] rf_aa, rf_ba, rf_da;
    logic [DW-1:0] rf_d;
    logic [DW-1:0] rf_a = '0;
    logic [DW-1:0] rf_b = '0;

    logic [DW-1:0] mem [16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_LOCK(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_lock(req0_lock),
        .req0_aa(req0_aa), .req0_ba(req0_ba), .req0_da(req0_da), .req0_wd(req0_wd),
        .rsp0_valid(rsp0_valid), .rsp0_a(rsp0_a), .rsp0_b(rsp0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_lock(req1_lock),
        .req1_aa(req1_aa), .req1_ba(req1_ba), .req1_da(req1_da), .req1_wd(req1_wd),
        .rsp1_valid(rsp1_valid), .rsp1_a(rsp1_a), .rsp1_b(rsp1_b),
        .rf_en(rf_en), .rf_rw(rf_rw), .rf_aa(rf_aa), .rf_ba(rf_ba), .rf_da(rf_da), .rf_d(rf_d),
        .rf_a(rf_a), .rf_b(rf_b)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        return 16'hA000 | 16'(a * 16'h0111);
    endfunction

    // Register file: registered read ports, same-edge read returns the old value.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
        end else if (rf_en) begin
            rf_a <= mem[rf_aa];
            rf_b <= mem[rf_ba];
            if (rf_rw) mem[rf_da] <= rf_d;
        end
    end

    task automatic idle_all();
        req0_valid = 0; req0_we = 0; req0_lock = 0; req0_aa = 0; req0_ba = 0; req0_da = 0; req0_wd = 0;
        req1_valid = 0; req1_we = 0; req1_lock = 0; req1_aa = 0; req1_ba = 0; req1_da = 0; req1_wd = 0;
    endtask

    task automatic next_beat();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1;
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        req0_valid = 1; req0_aa = 1; req0_ba = 2;
        req1_valid = 1; req1_aa = 3; req1_ba = 4;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({req1_ready, req0_ready, rf_en, rf_rw} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_ready: got rdy1,rdy0,en,rw=%b expected 0000", {req1_ready, req0_ready, rf_en, rf_rw});
            end
            checks++;
            if ({rsp1_valid, rsp0_valid, rsp0_a, rsp0_b, rsp1_a, rsp1_b} !== '0) begin
                errors++;
                $display("FAIL reset_rsp: got v1=%b v0=%b a0=%h b0=%h a1=%h b1=%h expected all 0",
                         rsp1_valid, rsp0_valid, rsp0_a, rsp0_b, rsp1_a, rsp1_b);
            end
        end
        next_beat();
        rst = 0;
        @(negedge clk);
        checks++;
        if ({req1_ready, req0_ready, rf_en, rf_aa} !== {3'b011, 4'd1}) begin
            errors++;
            $display("FAIL first_grant: got rdy1,rdy0,en=%b aa=%0d expected 011 aa=1", {req1_ready, req0_ready, rf_en}, rf_aa);
        end
        next_beat();
        checks++;
        if (dut.ptr !== 1'b1) begin
            errors++;
            $display("FAIL first_ptr: got %b expected 1", dut.ptr);
        end
        idle_all();
        @(negedge clk);
        checks++;
        if ({rsp1_valid, rsp0_valid, rsp0_a, rsp0_b} !== {2'b01, init_val(1), init_val(2)}) begin
            errors++;
            $display("FAIL first_rsp: got v=%b a0=%h b0=%h expected v=01 a0=%h b0=%h",
                     {rsp1_valid, rsp0_valid}, rsp0_a, rsp0_b, init_val(1), init_val(2));
        end
        next_beat();
    endtask

    task automatic test_fairness();
        logic [1:0]  exp_rdy;
        logic [63:0] exp_dat;
        int          p;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            if (i < 6) begin
                req0_valid = 1; req0_aa = 4'(i);     req0_ba = 4'(15 - i);
                req1_valid = 1; req1_aa = 4'(8 + i); req1_ba = 4'(i + 1);
            end else begin
                idle_all();
            end
            @(negedge clk);
            exp_rdy = (i >= 6) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
            checks++;
            if ({req1_ready, req0_ready} !== exp_rdy) begin
                errors++;
                $display("FAIL fair_grant[%0d]: got %b expected %b", i, {req1_ready, req0_ready}, exp_rdy);
            end
            if (i < 6) begin
                checks++;
                if (rf_aa !== ((i % 2 == 0) ? 4'(i) : 4'(8 + i))) begin
                    errors++;
                    $display("FAIL fair_rf_aa[%0d]: got %0d", i, rf_aa);
                end
            end
            if (i > 0) begin
                p = i - 1;
                if (p % 2 == 0) exp_dat = {init_val(p), init_val(15 - p), 32'h0};
                else            exp_dat = {32'h0, init_val(8 + p), init_val(p + 1)};
                checks++;
                if ({rsp1_valid, rsp0_valid} !== ((p % 2 == 0) ? 2'b01 : 2'b10) ||
                    {rsp0_a, rsp0_b, rsp1_a, rsp1_b} !== exp_dat) begin
                    errors++;
                    $display("FAIL fair_rsp[%0d]: got v=%b data=%h expected data=%h",
                             p, {rsp1_valid, rsp0_valid}, {rsp0_a, rsp0_b, rsp1_a, rsp1_b}, exp_dat);
                end
            end
            next_beat();
        end
    endtask

    task automatic test_write_readback();
        apply_reset();
        req0_valid = 1; req0_we = 1; req0_da = 5; req0_wd = 16'hBEEF; req0_aa = 5; req0_ba = 0;
        @(negedge clk);
        checks++;
        if ({rf_en, rf_rw, rf_da, rf_d, rf_aa} !== {2'b11, 4'd5, 16'hBEEF, 4'd5}) begin
            errors++;
            $display("FAIL wr_issue: got en,rw=%b da=%0d d=%h aa=%0d expected 11 5 beef 5", {rf_en, rf_rw}, rf_da, rf_d, rf_aa);
        end
        next_beat();
        idle_all();
        req1_valid = 1; req1_aa = 5; req1_ba = 6;
        @(negedge clk);
        checks++;
        if ({req1_ready, req0_ready, rf_rw} !== 3'b100) begin
            errors++;
            $display("FAIL rd_issue: got rdy1,rdy0,rw=%b expected 100", {req1_ready, req0_ready, rf_rw});
        end
        checks++;
        if ({rsp0_valid, rsp0_a, rsp0_b} !== {1'b1, 16'hA555, 16'hA000}) begin
            errors++;
            $display("FAIL wr_same_cycle_old: got v=%b a=%h b=%h expected 1 a555 a000", rsp0_valid, rsp0_a, rsp0_b);
        end
        next_beat();
        idle_all();
        @(negedge clk);
        checks++;
        if ({rsp1_valid, rsp1_a, rsp1_b} !== {1'b1, 16'hBEEF, 16'hA666}) begin
            errors++;
            $display("FAIL readback: got v=%b a=%h b=%h expected 1 beef a666", rsp1_valid, rsp1_a, rsp1_b);
        end
        next_beat();
    endtask

    task automatic test_lock_short();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            req0_valid = (i < 3); req0_lock = (i < 3); req0_aa = 4'(i);
            req1_valid = 1; req1_aa = 9;
            @(negedge clk);
            checks++;
            if ({req1_ready, req0_ready} !== ((i < 3) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL lock3_grant[%0d]: got %b", i, {req1_ready, req0_ready});
            end
            next_beat();
            if (i == 0) begin
                checks++;
                if (dut.state !== OWNED) begin
                    errors++;
                    $display("FAIL lock3_owned: got %0d expected OWNED", dut.state);
                end
            end
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL lock3_release: got %0d expected IDLE", dut.state);
        end
        idle_all();
        next_beat();
    endtask

    task automatic test_lock_forced();
        logic [1:0] exp_g [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            if (i < 6) begin
                req0_valid = 1; req0_lock = 1; req0_aa = 4'(i);
                req1_valid = 1; req1_aa = 4'(10);
            end else begin
                idle_all();
            end
            @(negedge clk);
            if (i < 6) begin
                checks++;
                if ({req1_ready, req0_ready} !== exp_g[i]) begin
                    errors++;
                    $display("FAIL forced_grant[%0d]: got %b expected %b", i, {req1_ready, req0_ready}, exp_g[i]);
                end
            end
            if (i > 0) begin
                checks++;
                if ({rsp1_valid, rsp0_valid} !== exp_g[i - 1]) begin
                    errors++;
                    $display("FAIL forced_rsp[%0d]: got %b expected %b", i - 1, {rsp1_valid, rsp0_valid}, exp_g[i - 1]);
                end
            end
            next_beat();
            if (i == 3) begin
                checks++;
                if (dut.lock_cnt !== 4'd4) begin
                    errors++;
                    $display("FAIL forced_cnt: got %0d expected 4", dut.lock_cnt);
                end
            end
            if (i == 4) begin
                checks++;
                if ({dut.ptr, dut.state} !== {1'b0, IDLE}) begin
                    errors++;
                    $display("FAIL forced_ptr_state: got ptr=%b state=%0d expected ptr=0 IDLE", dut.ptr, dut.state);
                end
            end
        end
    endtask

    task automatic test_lock_no_contention();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            req0_valid = 1; req0_lock = 1; req0_aa = 4'(i);
            @(negedge clk);
            checks++;
            if ({req1_ready, req0_ready} !== 2'b01) begin
                errors++;
                $display("FAIL solo_grant[%0d]: got %b expected 01", i, {req1_ready, req0_ready});
            end
            next_beat();
            if (i == 2) begin
                checks++;
                if (dut.lock_cnt !== 4'd3) begin
                    errors++;
                    $display("FAIL solo_cnt3: got %0d expected 3", dut.lock_cnt);
                end
            end
        end
        checks++;
        if ({dut.state, dut.lock_cnt} !== {OWNED, 4'd4}) begin
            errors++;
            $display("FAIL solo_saturate: got state=%0d cnt=%0d expected OWNED 4", dut.state, dut.lock_cnt);
        end
        idle_all();
        next_beat();
        checks++;
        if ({dut.state, dut.lock_cnt} !== {IDLE, 4'd0}) begin
            errors++;
            $display("FAIL solo_drop: got state=%0d cnt=%0d expected IDLE 0", dut.state, dut.lock_cnt);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req0_valid = 1; req0_aa = 3;
        @(negedge clk);
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL mid_grant: got %b expected 01", {req1_ready, req0_ready});
        end
        next_beat();
        rst = 1;
        req1_valid = 1;
        @(negedge clk);
        checks++;
        if ({rsp1_valid, rsp0_valid, req1_ready, req0_ready, rsp0_a} !== '0) begin
            errors++;
            $display("FAIL mid_cancel: got v=%b rdy=%b a0=%h expected all 0",
                     {rsp1_valid, rsp0_valid}, {req1_ready, req0_ready}, rsp0_a);
        end
        next_beat();
        checks++;
        if ({dut.state, dut.ptr} !== {IDLE, 1'b0}) begin
            errors++;
            $display("FAIL mid_state: got state=%0d ptr=%b expected IDLE 0", dut.state, dut.ptr);
        end
        rst = 0;
        idle_all();
        @(negedge clk);
        checks++;
        if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
            errors++;
            $display("FAIL mid_after: got %b expected 00", {rsp1_valid, rsp0_valid});
        end
        next_beat();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_fairness();
        test_write_readback();
        test_lock_short();
        test_lock_forced();
        test_lock_no_contention();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
